// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int PAR_NONE       = 0;
   localparam int PAR_EVEN       = 1;
   localparam int PAR_ODD        = 2;
   localparam int UART_DATA_BITS = 8;
   localparam int BIT_IDX_W      = $clog2(UART_DATA_BITS);

   // Even parity makes the total count of ones even; odd inverts that.
   function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                       input int mode);
      return (^data) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with last-cycle tick
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic bit_tick
);

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   assign bit_tick = (cnt_q == CNT_WIDTH'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || bit_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - byte-wide UART transmitter with busy/done handshake
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int PARITY       = 0,
   parameter int CNT_WIDTH    = $clog2(CLKS_PER_BIT)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] uart_dat_i,
   input  logic       uart_wr_i,
   output logic       o_Tx_Serial,
   output logic       uart_busy,
   output logic       o_Tx_Done
);

   import uart_pkg::*;

   tx_state_t                    state_q, state_d;
   logic [UART_DATA_BITS-1:0]    shift_q, shift_d;
   logic [BIT_IDX_W-1:0]         bit_idx_q, bit_idx_d;
   logic                         tx_q, tx_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         bit_tick;
   logic                         accept;

   assign accept = (state_q == IDLE) && uart_wr_i;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_WIDTH    (CNT_WIDTH)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst),
      .clr      (state_q == IDLE),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (uart_wr_i) begin
               shift_d = uart_dat_i;
               state_d = START;
            end
         end
         START: begin
            if (bit_tick) begin
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == BIT_IDX_W'(UART_DATA_BITS - 1)) begin
                  state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_tick) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered line tracks state_q exactly.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != IDLE);
      done_d = done_q;
      case (state_d)
         START:            tx_d = 1'b0;
         DATA:             tx_d = shift_d[bit_idx_d];
         uart_pkg::PARITY: tx_d = parity_bit(shift_d, PARITY);
         default:          tx_d = 1'b1;
      endcase
      if (accept) begin
         done_d = 1'b0;
      end else if ((state_q == STOP) && bit_tick) begin
         done_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign o_Tx_Serial = tx_q;
   assign uart_busy   = busy_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] dat = 8'h00;
   logic       wr0 = 1'b0;
   logic       wr1 = 1'b0;
   logic       wr2 = 1'b0;
   logic       tx0, busy0, done0;
   logic       tx1, busy1, done1;
   logic       tx2, busy2, done2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(0)) dut0 (
      .clk(clk), .rst(rst), .uart_dat_i(dat), .uart_wr_i(wr0),
      .o_Tx_Serial(tx0), .uart_busy(busy0), .o_Tx_Done(done0)
   );

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(1)) dut1 (
      .clk(clk), .rst(rst), .uart_dat_i(dat), .uart_wr_i(wr1),
      .o_Tx_Serial(tx1), .uart_busy(busy1), .o_Tx_Done(done1)
   );

   uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY(2)) dut2 (
      .clk(clk), .rst(rst), .uart_dat_i(dat), .uart_wr_i(wr2),
      .o_Tx_Serial(tx2), .uart_busy(busy2), .o_Tx_Done(done2)
   );

   // {line, busy, done} of the selected instance
   function automatic logic [2:0] obs(input int k);
      case (k)
         0:       return {tx0, busy0, done0};
         1:       return {tx1, busy1, done1};
         default: return {tx2, busy2, done2};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // Called at the first in-frame sample; ends on the first sample after the frame.
   task automatic expect_frame(input string tag, input int k, input int nbits,
                               input logic [10:0] frame);
      for (int i = 0; i < nbits * 4; i++) begin
         check(tag, obs(k), {frame[i/4], 1'b1, 1'b0});
         @(negedge clk);
      end
      check({tag, "_end"}, obs(k), 3'b101);
   endtask

   task automatic seq_byte(input logic [7:0] b, input logic [7:0] exp_b);
      int         n;
      logic [9:0] got;
      got = '0;
      dat = b;
      wr0 = 1'b1;
      n   = 0;
      @(negedge clk);
      while (!busy0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("seq_busy_seen", busy0, 1'b1);
      wr0 = 1'b0;
      for (int s = 0; s < 40; s++) begin
         if (s % 4 == 2) got[s/4] = tx0;
         @(negedge clk);
      end
      n = 0;
      while (!(!busy0 && done0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("seq_done_seen", {busy0, done0}, 2'b01);
      check("seq_byte", got, {1'b1, exp_b, 1'b0});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] word;
      logic [7:0]  exp_bytes [4];
      exp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};

      // reset values and idle line
      repeat (3) @(negedge clk);
      check("rst_d0", obs(0), 3'b100);
      check("rst_d1", obs(1), 3'b100);
      check("rst_d2", obs(2), 3'b100);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle", obs(0), 3'b100);
      end

      // no parity, 0xA5
      @(negedge clk); dat = 8'hA5; wr0 = 1'b1;
      @(negedge clk); wr0 = 1'b0;
      expect_frame("a5_nopar", 0, 10, 11'h34A);

      // even and odd parity, 0xA5
      @(negedge clk); dat = 8'hA5; wr1 = 1'b1;
      @(negedge clk); wr1 = 1'b0;
      expect_frame("a5_even", 1, 11, 11'h54A);
      @(negedge clk); dat = 8'hA5; wr2 = 1'b1;
      @(negedge clk); wr2 = 1'b0;
      expect_frame("a5_odd", 2, 11, 11'h74A);

      // write held high across two frames, data changed mid-frame
      @(negedge clk); dat = 8'h00; wr0 = 1'b1;
      @(negedge clk); dat = 8'hFF;
      expect_frame("hold_00", 0, 10, 11'h200);
      @(negedge clk); wr0 = 1'b0;
      expect_frame("hold_ff", 0, 10, 11'h3FE);

      // upstream sequencer pacing one 32-bit word, MSB byte first
      word = 32'h12345678;
      for (int k = 0; k < 4; k++) begin
         seq_byte(word[31-8*k -: 8], exp_bytes[k]);
      end

      // reset in the middle of data bit 3 of 0x3C
      @(negedge clk); dat = 8'h3C; wr0 = 1'b1;
      @(negedge clk); wr0 = 1'b0;
      repeat (16) @(negedge clk);
      check("3c_bit3", obs(0), 3'b110);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_d0", obs(0), 3'b100);
      check("abort_d1", obs(1), 3'b100);
      check("abort_d2", obs(2), 3'b100);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_idle", obs(0), 3'b100);
      dat = 8'h81; wr0 = 1'b1;
      @(negedge clk); wr0 = 1'b0;
      expect_frame("post_rst_81", 0, 10, 11'h302);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Byte-wide UART transmitter that sits directly downstream of the DFT word-to-byte sequencer. It accepts one byte per write strobe and serialises it onto a single TX line: start bit, 8 data bits LSB first, optional parity bit, then 1 stop bit. It reports `uart_busy` and `o_Tx_Done` back to the sequencer, which uses them to pace the 4 bytes of each 32-bit word.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); minimum legal value is 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- CNT_WIDTH, $clog2(CLKS_PER_BIT), width of the bit-period counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- uart_dat_i  input  8  byte to transmit; sampled on acceptance only.
- uart_wr_i  input  1  write request; level-sensitive, accepted only in IDLE.
- o_Tx_Serial  output  1  serial TX line; idles high.
- uart_busy  output  1  high while a frame is in flight.
- o_Tx_Done  output  1  sticky frame-complete flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: o_Tx_Serial=1, uart_busy=0, o_Tx_Done=0, state=IDLE, counters=0, shift register=0.
- All outputs are registered. Reset asserted mid-frame aborts the frame: the line returns high asynchronously and no done flag is set.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - line=1, busy=0.
  - If uart_wr_i=1 on a clk edge: latch uart_dat_i into the shift register, clear o_Tx_Done, go to START.
  - busy and line=0 become visible in the cycle after the accepting edge.
- START: line=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - line = shift_reg[bit_idx] for CLKS_PER_BIT cycles per bit.
  - After bit 7: go to PARITY if PARITY!=0, else STOP.
- PARITY: line = XOR of the latched byte (even), or its inverse (odd), for CLKS_PER_BIT cycles.
- STOP:
  - line=1 for CLKS_PER_BIT cycles.
  - On the final cycle: go to IDLE; busy drops and o_Tx_Done rises, both registered on the same edge.
- o_Tx_Done stays high in IDLE until the next write is accepted. It is never asserted before the first completed frame after reset.
- Bit counter: counts 0..CLKS_PER_BIT-1, wraps to 0 on every bit transition, and is held at 0 in IDLE.
- Frame length: busy is high for exactly (10 + (PARITY!=0)) × CLKS_PER_BIT cycles.
- uart_wr_i while busy (including the last STOP cycle) is ignored. A request held high through the end of a frame is accepted on the first IDLE edge, giving one idle-high cycle between frames.
- uart_dat_i changes after acceptance have no effect on the frame in flight.
- Handshake with the upstream sequencer:
  - The sequencer holds wr high until it sees busy, then waits for ~busy & o_Tx_Done.
  - This block guarantees that busy=1 is seen within one cycle of acceptance.
  - It also guarantees that ~busy & o_Tx_Done holds continuously from frame end until the next acceptance.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - Parity-mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - UART_DATA_BITS=8.
- Sub-module uart_baud_gen: a CLKS_PER_BIT counter with a synchronous clear and a bit_tick output that is high on the last cycle of each bit period. The FSM, shift register and bit index stay in uart_tx_serializer.

Test Plan:
All scenarios use CLKS_PER_BIT=4 unless a scenario states otherwise.
1. Reset, then idle 20 cycles -> line=1, busy=0, done=0 throughout.
2. PARITY=0, write 0xA5 for one cycle -> the next cycle starts line sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high exactly 40 cycles; done rises on the same edge busy falls.
3. PARITY=1 and PARITY=2, write 0xA5 -> parity bit 0 (even) and 1 (odd); busy high 44 cycles.
4. Hold uart_wr_i=1 continuously with data 0x00 then 0xFF -> 0x00 accepted; changing the data mid-frame does not alter its bits; 0xFF sent after exactly one idle cycle; done clears on the second acceptance.
5. Drive the upstream DFT sequencer with Data=32'h12345678 -> bytes 0x12, 0x34, 0x56, 0x78 appear on the line in order; no byte is dropped or duplicated.
6. Assert rst low during DATA bit 3 of 0x3C -> line=1 and busy=0 immediately; done=0. After release, a new write of 0x81 transmits a full, correct frame.
